// File: rtl/el2_dccm_init_ctrl.sv
// el2_dccm_init_ctrl: zero-fills every DCCM row after reset or on request, stalling core access meanwhile
module el2_dccm_init_ctrl #(
  parameter int DCCM_NUM_BANKS = 4,
  parameter int ROW_W = 10,
  parameter int DATA_W = 32,
  parameter int ECC_W = 7,
  parameter logic [ECC_W-1:0] INIT_ECC = '0,
  parameter bit AUTO_INIT = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst_l,
  input  logic                               init_req,
  output logic                               init_busy,
  output logic                               init_done,
  output logic                               core_stall,
  input  logic [DCCM_NUM_BANKS-1:0]          core_clken,
  input  logic [DCCM_NUM_BANKS-1:0]          core_wren,
  input  logic [DCCM_NUM_BANKS*ROW_W-1:0]    core_addr,
  input  logic [DCCM_NUM_BANKS*DATA_W-1:0]   core_wr_data,
  input  logic [DCCM_NUM_BANKS*ECC_W-1:0]    core_wr_ecc,
  output logic [DCCM_NUM_BANKS*DATA_W-1:0]   core_dout,
  output logic [DCCM_NUM_BANKS*ECC_W-1:0]    core_ecc,
  output logic [DCCM_NUM_BANKS-1:0]          mem_clken,
  output logic [DCCM_NUM_BANKS-1:0]          mem_wren,
  output logic [DCCM_NUM_BANKS*ROW_W-1:0]    mem_addr,
  output logic [DCCM_NUM_BANKS*DATA_W-1:0]   mem_wr_data,
  output logic [DCCM_NUM_BANKS*ECC_W-1:0]    mem_wr_ecc,
  input  logic [DCCM_NUM_BANKS*DATA_W-1:0]   mem_dout,
  input  logic [DCCM_NUM_BANKS*ECC_W-1:0]    mem_ecc
);
  typedef enum logic {IDLE, INIT} state_t;
  localparam state_t RST_STATE = AUTO_INIT ? INIT : IDLE;
  state_t state, state_nxt;
  logic [ROW_W-1:0] row, row_nxt;
  logic done_nxt;
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      state <= RST_STATE;
      row <= '0;
      init_done <= 1'b0;
    end else begin
      state <= state_nxt;
      row <= row_nxt;
      init_done <= done_nxt;
    end
  // row only ever leaves zero while sweeping, so IDLE can simply hold it at zero
  always_comb begin
    state_nxt = init_busy ? (&row ? IDLE : INIT) : (init_req ? INIT : IDLE);
    row_nxt = init_busy ? row + 1'b1 : '0;
    done_nxt = init_busy ? &row : init_done & ~init_req;
  end
  assign init_busy = state == INIT;
  assign core_stall = init_busy;
  assign mem_clken = init_busy ? '1 : core_clken;
  assign mem_wren = init_busy ? '1 : core_wren;
  assign mem_addr = init_busy ? {DCCM_NUM_BANKS{row}} : core_addr;
  assign mem_wr_data = init_busy ? '0 : core_wr_data;
  assign mem_wr_ecc = init_busy ? {DCCM_NUM_BANKS{INIT_ECC}} : core_wr_ecc;
  assign core_dout = mem_dout;
  assign core_ecc = mem_ecc;
endmodule

// File: tb/tb_el2_dccm_init_ctrl.sv
// tb_el2_dccm_init_ctrl: scoreboard bench for the DCCM init controller, auto-init and manual-init instances
module tb_el2_dccm_init_ctrl;
  localparam int NB = 4, RW = 4, DW = 32, EW = 7;
  localparam logic [EW-1:0] IECC = 7'h55;
  typedef struct packed {
    logic busy, done, stall;
    logic [NB-1:0] clken, wren;
    logic [NB*RW-1:0] addr;
    logic [NB*DW-1:0] wdata;
    logic [NB*EW-1:0] wecc;
    logic [NB*DW-1:0] dout;
    logic [NB*EW-1:0] decc;
  } obs_t;
  logic clk, rst_l, init_req;
  logic [NB-1:0] core_clken, core_wren;
  logic [NB*RW-1:0] core_addr;
  logic [NB*DW-1:0] core_wr_data, mem_dout;
  logic [NB*EW-1:0] core_wr_ecc, mem_ecc;
  logic busy, done, stall, busy0, done0, stall0;
  logic [NB*DW-1:0] core_dout, core_dout0, mem_wr_data, mem_wr_data0;
  logic [NB*EW-1:0] core_ecc, core_ecc0, mem_wr_ecc, mem_wr_ecc0;
  logic [NB-1:0] mem_clken, mem_wren, mem_clken0, mem_wren0;
  logic [NB*RW-1:0] mem_addr, mem_addr0;
  logic [DW-1:0] mdata [NB][16];
  logic [EW-1:0] mecc [NB][16];
  obs_t q[$], q0[$];
  int checks = 0, errors = 0;

  el2_dccm_init_ctrl #(.DCCM_NUM_BANKS(NB), .ROW_W(RW), .DATA_W(DW), .ECC_W(EW),
    .INIT_ECC(IECC), .AUTO_INIT(1'b1)) dut (
    .clk(clk), .rst_l(rst_l), .init_req(init_req), .init_busy(busy), .init_done(done),
    .core_stall(stall), .core_clken(core_clken), .core_wren(core_wren), .core_addr(core_addr),
    .core_wr_data(core_wr_data), .core_wr_ecc(core_wr_ecc), .core_dout(core_dout),
    .core_ecc(core_ecc), .mem_clken(mem_clken), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_ecc(mem_wr_ecc), .mem_dout(mem_dout), .mem_ecc(mem_ecc));

  el2_dccm_init_ctrl #(.DCCM_NUM_BANKS(NB), .ROW_W(RW), .DATA_W(DW), .ECC_W(EW),
    .INIT_ECC(IECC), .AUTO_INIT(1'b0)) dut0 (
    .clk(clk), .rst_l(rst_l), .init_req(1'b0), .init_busy(busy0), .init_done(done0),
    .core_stall(stall0), .core_clken(core_clken), .core_wren(core_wren), .core_addr(core_addr),
    .core_wr_data(core_wr_data), .core_wr_ecc(core_wr_ecc), .core_dout(core_dout0),
    .core_ecc(core_ecc0), .mem_clken(mem_clken0), .mem_wren(mem_wren0), .mem_addr(mem_addr0),
    .mem_wr_data(mem_wr_data0), .mem_wr_ecc(mem_wr_ecc0), .mem_dout(mem_dout), .mem_ecc(mem_ecc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [511:0] a, input logic [511:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic obs_t exp_init(input int r);
    logic [RW-1:0] rr;
    obs_t o;
    rr = r[RW-1:0];
    o = '{busy: 1'b1, done: 1'b0, stall: 1'b1, clken: '1, wren: '1, addr: {NB{rr}},
          wdata: '0, wecc: {NB{IECC}}, dout: mem_dout, decc: mem_ecc};
    return o;
  endfunction

  function automatic obs_t exp_core(input logic b, input logic d);
    obs_t o;
    o = '{busy: b, done: d, stall: b, clken: core_clken, wren: core_wren, addr: core_addr,
          wdata: core_wr_data, wecc: core_wr_ecc, dout: mem_dout, decc: mem_ecc};
    return o;
  endfunction

  // SRAM-side monitor: every cycle with a bank enabled must match the next expected request
  always @(negedge clk) if (rst_l) begin
    if (mem_clken != '0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL main_unexpected_req: got addr %h clken %h expected no request", mem_addr, mem_clken);
      end else
        chk("main_req", {busy, done, stall, mem_clken, mem_wren, mem_addr, mem_wr_data, mem_wr_ecc,
                         core_dout, core_ecc}, q.pop_front());
      for (int b = 0; b < NB; b++)
        if (mem_wren[b]) begin
          mdata[b][mem_addr[b*RW+:RW]] <= mem_wr_data[b*DW+:DW];
          mecc[b][mem_addr[b*RW+:RW]] <= mem_wr_ecc[b*EW+:EW];
        end
    end
    if (mem_clken0 != '0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL noauto_unexpected_req: got addr %h clken %h expected no request", mem_addr0, mem_clken0);
      end else
        chk("noauto_req", {busy0, done0, stall0, mem_clken0, mem_wren0, mem_addr0, mem_wr_data0,
                           mem_wr_ecc0, core_dout0, core_ecc0}, q0.pop_front());
    end
  end

  initial begin
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < 16; r++) begin
        mdata[b][r] = '1;
        mecc[b][r] = '1;
      end
    rst_l = 1'b0;
    init_req = 1'b0;
    core_clken = '0; core_wren = '0; core_addr = '0; core_wr_data = '0; core_wr_ecc = '0;
    mem_dout = 128'h0123456789ABCDEF_FEDCBA9876543210;
    mem_ecc = 28'h1234567;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst0_busy", busy0, 0);
    chk("rst0_done", done0, 0);
    // core holds a bank-2 write to row 5 through the whole auto sweep
    core_clken = 4'b0100;
    core_wren = 4'b0100;
    core_addr = 16'h0500;
    core_wr_data = {32'h0, 32'hDEADBEEF, 64'h0};
    core_wr_ecc = {7'h0, 7'h2A, 14'h0};
    for (int r = 0; r < 16; r++) q.push_back(exp_init(r));
    q.push_back(exp_core(1'b0, 1'b1));
    repeat (17) q0.push_back(exp_core(1'b0, 1'b0));
    rst_l = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    core_clken = '0; core_wren = '0; core_addr = '0; core_wr_data = '0; core_wr_ecc = '0;
    chk("auto_busy_end", busy, 0);
    chk("auto_done_end", done, 1);
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < 16; r++) begin
        chk($sformatf("model_data_b%0d_r%0d", b, r), mdata[b][r],
            (b == 2 && r == 5) ? 32'hDEADBEEF : 32'h0);
        chk($sformatf("model_ecc_b%0d_r%0d", b, r), mecc[b][r],
            (b == 2 && r == 5) ? 7'h2A : IECC);
      end
    // re-init with a second pulse at row 7 that must be ignored
    @(posedge clk);
    #1 init_req = 1'b1;
    for (int r = 0; r < 16; r++) q.push_back(exp_init(r));
    @(posedge clk);
    #1 init_req = 1'b0;
    repeat (7) @(posedge clk);
    #1 init_req = 1'b1;
    @(posedge clk);
    #1 init_req = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("reinit_busy_end", busy, 0);
    chk("reinit_done_end", done, 1);
    // reset during row 9 of a sweep
    @(posedge clk);
    #1 init_req = 1'b1;
    for (int r = 0; r < 9; r++) q.push_back(exp_init(r));
    @(posedge clk);
    #1 init_req = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_l = 1'b0;
    #1;
    chk("midrst_busy", busy, 1);
    chk("midrst_done", done, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_queue", q.size(), 0);
    @(posedge clk);
    #1;
    for (int r = 0; r < 16; r++) q.push_back(exp_init(r));
    rst_l = 1'b1;
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("restart_busy_end", busy, 0);
    chk("restart_done_end", done, 1);
    chk("noauto_busy", busy0, 0);
    chk("noauto_done", done0, 0);
    // idle passthrough, write then read, with new SRAM return data
    @(posedge clk);
    #1;
    mem_dout = 128'hCAFEF00D_13579BDF_2468ACE0_0BADC0DE;
    mem_ecc = 28'hABCDEF1;
    core_clken = 4'b1111; core_wren = 4'b1010; core_addr = 16'hA5C3;
    core_wr_data = 128'h11112222_33334444_55556666_77778888;
    core_wr_ecc = 28'h7654321;
    q.push_back(exp_core(1'b0, 1'b1));
    q0.push_back(exp_core(1'b0, 1'b0));
    @(posedge clk);
    #1;
    mem_dout = 128'h89ABCDEF_01234567_FFFF0000_A5A55A5A;
    mem_ecc = 28'h0F0F0F0;
    core_clken = 4'b1001; core_wren = 4'b0000; core_addr = 16'h3F07;
    core_wr_data = '0; core_wr_ecc = '0;
    q.push_back(exp_core(1'b0, 1'b1));
    q0.push_back(exp_core(1'b0, 1'b0));
    @(posedge clk);
    #1;
    core_clken = '0; core_wren = '0; core_addr = '0;
    @(negedge clk);
    chk("final_queue", q.size(), 0);
    chk("final_queue0", q0.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
